// File: rtl/mips_multicycle_sequencer.sv
// Control sequencer for a multicycle MIPS-I datapath: walks FETCH/EXEC1/EXEC2/MULDIV/HALT
// and decodes the instruction class to drive memory strobes and datapath write enables.
module mips_multicycle_sequencer #(
  parameter int ADDR_W      = 32,
  parameter int MULT_CYCLES = 1,
  parameter int DIV_CYCLES  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instruction,
  input  logic [ADDR_W-1:0] pc,
  input  logic              waitrequest,
  output logic [2:0]        state,
  output logic              mem_read,
  output logic              mem_write,
  output logic              ir_load,
  output logic              pc_update,
  output logic              reg_write,
  output logic              hilo_write,
  output logic              active,
  output logic              illegal
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    EXEC1  = 3'd1,
    EXEC2  = 3'd2,
    MULDIV = 3'd3,
    HALT   = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    CLS_LOAD,
    CLS_STORE,
    CLS_MULDIV,
    CLS_OTHER,
    CLS_ILLEGAL
  } op_class_t;

  // The counter is preloaded with N-2 so that EXEC1 plus N-1 MULDIV cycles totals N.
  localparam int MULT_LOAD_I = (MULT_CYCLES > 1) ? MULT_CYCLES - 2 : 0;
  localparam int DIV_LOAD_I  = (DIV_CYCLES > 1) ? DIV_CYCLES - 2 : 0;
  localparam logic [5:0] MULT_LOAD = MULT_LOAD_I[5:0];
  localparam logic [5:0] DIV_LOAD  = DIV_LOAD_I[5:0];
  localparam bit MULT_SINGLE = (MULT_CYCLES == 1);
  localparam bit DIV_SINGLE  = (DIV_CYCLES == 1);

  state_t    state_q, state_d;
  logic [5:0] count_q, count_d;
  logic      illegal_q, illegal_d;

  op_class_t op_class;
  logic      link_write;
  logic      is_div;

  logic [5:0] opcode;
  logic [4:0] rt;
  logic [5:0] funct;
  logic       unused_bits;

  assign opcode      = instruction[31:26];
  assign rt          = instruction[20:16];
  assign funct       = instruction[5:0];
  assign unused_bits = ^{instruction[25:21], instruction[15:6]};

  always_comb begin
    op_class   = CLS_ILLEGAL;
    link_write = 1'b0;
    is_div     = 1'b0;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
          6'h09, 6'h10, 6'h12,
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
          6'h2A, 6'h2B: begin
            op_class   = CLS_OTHER;
            link_write = 1'b1;
          end
          6'h08, 6'h0C, 6'h0D, 6'h11, 6'h13: op_class = CLS_OTHER;
          6'h18, 6'h19: op_class = CLS_MULDIV;
          6'h1A, 6'h1B: begin
            op_class = CLS_MULDIV;
            is_div   = 1'b1;
          end
          default: op_class = CLS_ILLEGAL;
        endcase
      end
      // REGIMM: the AL forms link even when the branch is not taken.
      6'h01: begin
        case (rt)
          5'h00, 5'h01: op_class = CLS_OTHER;
          5'h10, 5'h11: begin
            op_class   = CLS_OTHER;
            link_write = 1'b1;
          end
          default: op_class = CLS_ILLEGAL;
        endcase
      end
      6'h02, 6'h04, 6'h05, 6'h06, 6'h07: op_class = CLS_OTHER;
      6'h03, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
        op_class   = CLS_OTHER;
        link_write = 1'b1;
      end
      6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26: op_class = CLS_LOAD;
      6'h28, 6'h29, 6'h2B: op_class = CLS_STORE;
      6'h2A, 6'h2E: op_class = CLS_OTHER;
      default: op_class = CLS_ILLEGAL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= FETCH;
      count_q   <= 6'd0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    illegal_d = illegal_q;
    case (state_q)
      FETCH: begin
        if (pc == '0)
          state_d = HALT;
        else if (!waitrequest)
          state_d = EXEC1;
      end
      EXEC1: begin
        case (op_class)
          CLS_LOAD:  if (!waitrequest) state_d = EXEC2;
          CLS_STORE: if (!waitrequest) state_d = FETCH;
          CLS_MULDIV: begin
            if (is_div ? DIV_SINGLE : MULT_SINGLE) begin
              state_d = FETCH;
            end else begin
              count_d = is_div ? DIV_LOAD : MULT_LOAD;
              state_d = MULDIV;
            end
          end
          CLS_OTHER: state_d = FETCH;
          default: begin
            illegal_d = 1'b1;
            state_d   = HALT;
          end
        endcase
      end
      EXEC2: state_d = FETCH;
      MULDIV: begin
        if (count_q == 6'd0)
          state_d = FETCH;
        else
          count_d = count_q - 6'd1;
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  // Every strobe and enable is forced low while reset is held so an abort never writes.
  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_load    = 1'b0;
    pc_update  = 1'b0;
    reg_write  = 1'b0;
    hilo_write = 1'b0;
    active     = (state_q != HALT) || reset;
    illegal    = 1'b0;
    if (!reset) begin
      illegal = illegal_q;
      case (state_q)
        FETCH: begin
          if (pc != '0) begin
            mem_read = 1'b1;
            ir_load  = !waitrequest;
          end
        end
        EXEC1: begin
          case (op_class)
            CLS_LOAD: mem_read = 1'b1;
            CLS_STORE: begin
              mem_write = 1'b1;
              pc_update = !waitrequest;
            end
            CLS_MULDIV: begin
              if (is_div ? DIV_SINGLE : MULT_SINGLE) begin
                hilo_write = 1'b1;
                pc_update  = 1'b1;
              end
            end
            CLS_OTHER: begin
              reg_write = link_write;
              pc_update = 1'b1;
            end
            default: illegal = 1'b1;
          endcase
        end
        EXEC2: begin
          reg_write = 1'b1;
          pc_update = 1'b1;
        end
        MULDIV: begin
          if (count_q == 6'd0) begin
            hilo_write = 1'b1;
            pc_update  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_mips_multicycle_sequencer.sv
// Directed bench for mips_multicycle_sequencer: each task walks one scenario cycle by cycle
// and compares the control outputs against hand-derived values.
module tb_mips_multicycle_sequencer;

  logic        clk;
  logic        reset;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        waitrequest;
  logic [2:0]  state;
  logic        mem_read, mem_write, ir_load, pc_update;
  logic        reg_write, hilo_write, active, illegal;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] I_ADDIU = 32'h24010005;
  localparam logic [31:0] I_LW    = 32'h8C220000;
  localparam logic [31:0] I_SW    = 32'hAC220000;
  localparam logic [31:0] I_MULT  = 32'h00220018;
  localparam logic [31:0] I_DIV   = 32'h0022001A;

  mips_multicycle_sequencer #(
    .ADDR_W(32),
    .MULT_CYCLES(1),
    .DIV_CYCLES(32)
  ) dut (
    .clk(clk),
    .reset(reset),
    .instruction(instruction),
    .pc(pc),
    .waitrequest(waitrequest),
    .state(state),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .ir_load(ir_load),
    .pc_update(pc_update),
    .reg_write(reg_write),
    .hilo_write(hilo_write),
    .active(active),
    .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Inputs change on the falling edge; outputs are observed 1 ns later.
  task automatic drive(input logic [31:0] i, input logic [31:0] p, input logic w);
    @(negedge clk);
    instruction = i;
    pc          = p;
    waitrequest = w;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; pc = 32'd4; waitrequest = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; instruction = I_ADDIU; pc = 32'd4; waitrequest = 1'b0;
    #1;
    checks++; if (state !== 3'd0) begin errors++; $display("[TB] FAIL reset_state: got %0d expected 0", state); end
    checks++; if (mem_read !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_read: got %b expected 0", mem_read); end
    checks++; if (ir_load !== 1'b0) begin errors++; $display("[TB] FAIL reset_ir_load: got %b expected 0", ir_load); end
    checks++; if (active !== 1'b1) begin errors++; $display("[TB] FAIL reset_active: got %b expected 1", active); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("[TB] FAIL reset_illegal: got %b expected 0", illegal); end
    waitrequest = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (state !== 3'd0 || mem_read !== 1'b1) begin errors++; $display("[TB] FAIL first_fetch: got state=%0d rd=%b expected state=0 rd=1", state, mem_read); end
  endtask

  task automatic test_other();
    logic [31:0] instrs [9] = '{I_ADDIU, 32'h03E00008, 32'h0C000010, 32'h04110004, 32'h00200011,
                                32'h10000004, 32'h3C011234, 32'h00011080, 32'h00001012};
    logic        rws    [9] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int k = 0; k < 9; k++) begin
      drive(instrs[k], 32'd4, 1'b0);
      checks++; if (state !== 3'd0 || mem_read !== 1'b1 || ir_load !== 1'b1) begin errors++; $display("[TB] FAIL other_fetch[%0d]: got state=%0d rd=%b ir=%b expected 0/1/1", k, state, mem_read, ir_load); end
      drive(instrs[k], 32'd4, 1'b0);
      checks++; if (state !== 3'd1) begin errors++; $display("[TB] FAIL other_exec1_state[%0d]: got %0d expected 1", k, state); end
      checks++; if (reg_write !== rws[k]) begin errors++; $display("[TB] FAIL other_reg_write[%0d]: got %b expected %b", k, reg_write, rws[k]); end
      checks++; if (pc_update !== 1'b1 || mem_read !== 1'b0 || mem_write !== 1'b0 || hilo_write !== 1'b0) begin errors++; $display("[TB] FAIL other_ctrl[%0d]: got pcu=%b rd=%b wr=%b hl=%b expected 1/0/0/0", k, pc_update, mem_read, mem_write, hilo_write); end
      drive(instrs[k], 32'd4, 1'b1);
      checks++; if (state !== 3'd0) begin errors++; $display("[TB] FAIL other_return[%0d]: got %0d expected 0", k, state); end
    end
  endtask

  task automatic test_load_wait();
    drive(I_LW, 32'd4, 1'b1);
    checks++; if (state !== 3'd0 || mem_read !== 1'b1 || ir_load !== 1'b0) begin errors++; $display("[TB] FAIL fetch_wait: got state=%0d rd=%b ir=%b expected 0/1/0", state, mem_read, ir_load); end
    drive(I_LW, 32'd4, 1'b0);
    checks++; if (ir_load !== 1'b1) begin errors++; $display("[TB] FAIL load_ir_load: got %b expected 1", ir_load); end
    for (int k = 0; k < 3; k++) begin
      drive(I_LW, 32'd4, 1'b1);
      checks++; if (state !== 3'd1 || mem_read !== 1'b1 || mem_write !== 1'b0 || reg_write !== 1'b0 || pc_update !== 1'b0) begin errors++; $display("[TB] FAIL load_hold[%0d]: got state=%0d rd=%b wr=%b rw=%b pcu=%b expected 1/1/0/0/0", k, state, mem_read, mem_write, reg_write, pc_update); end
    end
    drive(I_LW, 32'd4, 1'b0);
    checks++; if (state !== 3'd1 || mem_read !== 1'b1 || pc_update !== 1'b0) begin errors++; $display("[TB] FAIL load_done: got state=%0d rd=%b pcu=%b expected 1/1/0", state, mem_read, pc_update); end
    drive(I_LW, 32'd4, 1'b1);
    checks++; if (state !== 3'd2 || reg_write !== 1'b1 || pc_update !== 1'b1 || mem_read !== 1'b0) begin errors++; $display("[TB] FAIL load_exec2: got state=%0d rw=%b pcu=%b rd=%b expected 2/1/1/0", state, reg_write, pc_update, mem_read); end
    drive(I_LW, 32'd4, 1'b1);
    checks++; if (state !== 3'd0) begin errors++; $display("[TB] FAIL load_return: got %0d expected 0", state); end
  endtask

  task automatic test_store();
    drive(I_SW, 32'd4, 1'b0);
    drive(I_SW, 32'd4, 1'b1);
    checks++; if (state !== 3'd1 || mem_write !== 1'b1 || mem_read !== 1'b0 || pc_update !== 1'b0) begin errors++; $display("[TB] FAIL store_hold: got state=%0d wr=%b rd=%b pcu=%b expected 1/1/0/0", state, mem_write, mem_read, pc_update); end
    drive(I_SW, 32'd4, 1'b0);
    checks++; if (mem_write !== 1'b1 || pc_update !== 1'b1 || reg_write !== 1'b0) begin errors++; $display("[TB] FAIL store_done: got wr=%b pcu=%b rw=%b expected 1/1/0", mem_write, pc_update, reg_write); end
    drive(I_SW, 32'd4, 1'b1);
    checks++; if (state !== 3'd0) begin errors++; $display("[TB] FAIL store_return: got %0d expected 0", state); end
  endtask

  task automatic test_mult_single();
    drive(I_MULT, 32'd4, 1'b0);
    drive(I_MULT, 32'd4, 1'b1);
    checks++; if (state !== 3'd1 || hilo_write !== 1'b1 || pc_update !== 1'b1 || reg_write !== 1'b0) begin errors++; $display("[TB] FAIL mult_exec1: got state=%0d hl=%b pcu=%b rw=%b expected 1/1/1/0", state, hilo_write, pc_update, reg_write); end
    drive(I_MULT, 32'd4, 1'b1);
    checks++; if (state !== 3'd0) begin errors++; $display("[TB] FAIL mult_return: got %0d expected 0", state); end
  endtask

  task automatic test_div_countdown();
    int exec_cycles = 0;
    int hilo_cnt = 0;
    int hilo_at = -1;
    int bad = 0;
    drive(I_DIV, 32'd4, 1'b0);
    for (int cyc = 0; cyc < 40; cyc++) begin
      drive(I_DIV, 32'd4, 1'b1);
      if (cyc == 0) begin
        checks++; if (state !== 3'd1) begin errors++; $display("[TB] FAIL div_first_state: got %0d expected 1", state); end
      end
      if (state == 3'd0) break;
      exec_cycles++;
      if (hilo_write) begin hilo_cnt++; hilo_at = cyc; end
      if (reg_write || mem_read || mem_write || (pc_update && !hilo_write)) bad++;
    end
    checks++; if (exec_cycles != 32) begin errors++; $display("[TB] FAIL div_exec_cycles: got %0d expected 32", exec_cycles); end
    checks++; if (hilo_cnt != 1) begin errors++; $display("[TB] FAIL div_hilo_count: got %0d expected 1", hilo_cnt); end
    checks++; if (hilo_at != 31) begin errors++; $display("[TB] FAIL div_hilo_cycle: got %0d expected 31", hilo_at); end
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL div_stray_enables: got %0d expected 0", bad); end
    checks++; if (state !== 3'd0) begin errors++; $display("[TB] FAIL div_return: got %0d expected 0", state); end
  endtask

  task automatic test_reset_during_div();
    int hilo_seen = 0;
    drive(I_DIV, 32'd4, 1'b0);
    drive(I_DIV, 32'd4, 1'b1);
    for (int k = 0; k < 5; k++) begin
      drive(I_DIV, 32'd4, 1'b1);
      if (hilo_write) hilo_seen++;
    end
    checks++; if (state !== 3'd3) begin errors++; $display("[TB] FAIL div_in_muldiv: got %0d expected 3", state); end
    #2 reset = 1'b1;
    #1;
    checks++; if (state !== 3'd0 || hilo_write !== 1'b0 || active !== 1'b1) begin errors++; $display("[TB] FAIL div_async_reset: got state=%0d hl=%b act=%b expected 0/0/1", state, hilo_write, active); end
    @(negedge clk);
    if (hilo_write) hilo_seen++;
    waitrequest = 1'b1;
    reset = 1'b0;
    checks++; if (hilo_seen != 0) begin errors++; $display("[TB] FAIL div_reset_hilo: got %0d expected 0", hilo_seen); end
    drive(I_ADDIU, 32'd4, 1'b0);
    checks++; if (state !== 3'd0 || mem_read !== 1'b1) begin errors++; $display("[TB] FAIL div_reset_refetch: got state=%0d rd=%b expected 0/1", state, mem_read); end
    drive(I_ADDIU, 32'd4, 1'b1);
    do_reset();
  endtask

  task automatic test_illegal();
    logic [31:0] bad_instrs [3] = '{32'hFC000000, 32'h04050000, 32'h00000001};
    for (int k = 0; k < 3; k++) begin
      drive(bad_instrs[k], 32'd4, 1'b0);
      drive(bad_instrs[k], 32'd4, 1'b0);
      checks++; if (state !== 3'd1 || illegal !== 1'b1) begin errors++; $display("[TB] FAIL illegal_decode[%0d]: got state=%0d ill=%b expected 1/1", k, state, illegal); end
      checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0 || reg_write !== 1'b0 || hilo_write !== 1'b0 || pc_update !== 1'b0) begin errors++; $display("[TB] FAIL illegal_enables[%0d]: got rd=%b wr=%b rw=%b hl=%b pcu=%b expected all 0", k, mem_read, mem_write, reg_write, hilo_write, pc_update); end
      drive(I_ADDIU, 32'd4, 1'b0);
      checks++; if (state !== 3'd4 || active !== 1'b0 || illegal !== 1'b1) begin errors++; $display("[TB] FAIL illegal_halt[%0d]: got state=%0d act=%b ill=%b expected 4/0/1", k, state, active, illegal); end
      repeat (10) drive(I_ADDIU, 32'd4, 1'b0);
      checks++; if (state !== 3'd4 || active !== 1'b0 || illegal !== 1'b1 || mem_read !== 1'b0) begin errors++; $display("[TB] FAIL illegal_absorb[%0d]: got state=%0d act=%b ill=%b rd=%b expected 4/0/1/0", k, state, active, illegal, mem_read); end
      @(negedge clk);
      reset = 1'b1; waitrequest = 1'b1;
      #1;
      checks++; if (illegal !== 1'b0 || state !== 3'd0 || active !== 1'b1) begin errors++; $display("[TB] FAIL illegal_clear[%0d]: got ill=%b state=%0d act=%b expected 0/0/1", k, illegal, state, active); end
      @(negedge clk);
      reset = 1'b0;
    end
  endtask

  task automatic test_pc_zero();
    drive(I_ADDIU, 32'd0, 1'b0);
    checks++; if (state !== 3'd0 || mem_read !== 1'b0 || ir_load !== 1'b0) begin errors++; $display("[TB] FAIL pc0_fetch: got state=%0d rd=%b ir=%b expected 0/0/0", state, mem_read, ir_load); end
    drive(I_ADDIU, 32'd4, 1'b0);
    checks++; if (state !== 3'd4 || active !== 1'b0 || mem_read !== 1'b0 || illegal !== 1'b0) begin errors++; $display("[TB] FAIL pc0_halt: got state=%0d act=%b rd=%b ill=%b expected 4/0/0/0", state, active, mem_read, illegal); end
    do_reset();
  endtask

  initial begin
    reset = 1'b1;
    instruction = 32'h0;
    pc = 32'd4;
    waitrequest = 1'b1;
    test_reset();
    test_other();
    test_load_wait();
    test_store();
    test_mult_single();
    test_div_countdown();
    test_reset_during_div();
    test_illegal();
    test_pc_zero();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
